// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults, phase encoding and sync-level helper.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int CNT_W   = 10;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    function automatic logic sync_level(input phase_t ph, input logic pol);
        return (ph == PH_SYNC) ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase register.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    output logic [CNT_W-1:0] count,
    output phase_t           phase,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_TOTAL  = CNT_W'(ACTIVE + FP + SYNC + BP - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    phase_t           r_phase;
    phase_t           w_phase_next;

    assign wrap  = adv & (r_count == LAST_TOTAL);
    assign count = r_count;
    assign phase = r_phase;

    // Next position and phase; a phase ends only on an advance at its last value.
    always_comb begin
        w_count_next = r_count;
        w_phase_next = r_phase;
        if (adv) begin
            if (r_count == LAST_TOTAL) begin
                w_count_next = CNT_ZERO;
            end else begin
                w_count_next = r_count + CNT_ONE;
            end
            case (r_phase)
                PH_ACTIVE: begin
                    if (r_count == LAST_ACTIVE) w_phase_next = PH_FRONT;
                    else                        w_phase_next = PH_ACTIVE;
                end
                PH_FRONT: begin
                    if (r_count == LAST_FRONT) w_phase_next = PH_SYNC;
                    else                       w_phase_next = PH_FRONT;
                end
                PH_SYNC: begin
                    if (r_count == LAST_SYNC) w_phase_next = PH_BACK;
                    else                      w_phase_next = PH_SYNC;
                end
                PH_BACK: begin
                    if (r_count == LAST_TOTAL) w_phase_next = PH_ACTIVE;
                    else                       w_phase_next = PH_BACK;
                end
                default: w_phase_next = PH_ACTIVE;
            endcase
        end else begin
            w_count_next = r_count;
            w_phase_next = r_phase;
        end
    end

    // Position and phase state; reset parks on the last position of the back porch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= LAST_TOTAL;
            r_phase <= PH_BACK;
        end else begin
            r_count <= w_count_next;
            r_phase <= w_phase_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator driven by a pixel-rate clock enable derived from a divider tap.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_tap,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic             r_tap_q;
    logic             w_tick;
    logic             w_v_adv;
    logic [CNT_W-1:0] w_h_count;
    logic [CNT_W-1:0] w_v_count;
    phase_t           w_h_phase;
    phase_t           w_v_phase;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             r_line_evt;
    logic             r_frame_evt;

    assign w_tick  = div_tap & ~r_tap_q;
    assign w_v_adv = w_tick & w_h_wrap;

    // Divider tap history for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tap_q <= 1'b0;
        end else begin
            r_tap_q <= div_tap;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (w_tick),
        .count  (w_h_count),
        .phase  (w_h_phase),
        .wrap   (w_h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (w_v_adv),
        .count  (w_v_count),
        .phase  (w_v_phase),
        .wrap   (w_v_wrap)
    );

    // Wrap strobes captured alongside the counter update so pulses line up with the new position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line_evt  <= 1'b0;
            r_frame_evt <= 1'b0;
        end else begin
            r_line_evt  <= w_h_wrap;
            r_frame_evt <= w_v_wrap;
        end
    end

    // Output register stage: every output changes on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount      <= H_LAST;
            vcount      <= V_LAST;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= w_h_count;
            vcount      <= w_v_count;
            hsync       <= sync_level(w_h_phase, SYNC_POL);
            vsync       <= sync_level(w_v_phase, SYNC_POL);
            video_on    <= (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);
            line_start  <= r_line_evt;
            frame_start <= r_frame_evt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full-size 640x480 instance plus a shrunken instance for frame-level behaviour.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       ls;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic div_tap;

    logic [9:0] hcount0, vcount0, hcount1, vcount1;
    logic hsync0, vsync0, video_on0, line_start0, frame_start0;
    logic hsync1, vsync1, video_on1, line_start1, frame_start1;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_full (
        .clk         (clk),
        .reset       (reset),
        .div_tap     (div_tap),
        .hcount      (hcount0),
        .vcount      (vcount0),
        .hsync       (hsync0),
        .vsync       (vsync0),
        .video_on    (video_on0),
        .line_start  (line_start0),
        .frame_start (frame_start0)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b1)
    ) u_dut_small (
        .clk         (clk),
        .reset       (reset),
        .div_tap     (div_tap),
        .hcount      (hcount1),
        .vcount      (vcount1),
        .hsync       (hsync1),
        .vsync       (vsync1),
        .video_on    (video_on1),
        .line_start  (line_start1),
        .frame_start (frame_start1)
    );

    int   p_ha[2] = '{640, 8};
    int   p_hf[2] = '{16, 2};
    int   p_hs[2] = '{96, 3};
    int   p_hb[2] = '{48, 2};
    int   p_va[2] = '{480, 6};
    int   p_vf[2] = '{10, 2};
    int   p_vs[2] = '{2, 2};
    int   p_vb[2] = '{33, 3};
    logic p_pol[2] = '{1'b0, 1'b1};

    int   n_checks = 0;
    int   n_errors = 0;

    int   m_h[2];
    int   m_v[2];
    logic m_le[2];
    logic m_fe[2];
    logic m_tap_q;
    exp_t e_out[2];
    exp_t q0[$];
    exp_t q1[$];

    logic meas_en = 1'b0;
    int   tapc = 0;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int htot(input int k);
        return p_ha[k] + p_hf[k] + p_hs[k] + p_hb[k];
    endfunction

    function automatic int vtot(input int k);
        return p_va[k] + p_vf[k] + p_vs[k] + p_vb[k];
    endfunction

    function automatic exp_t decode(input int k, input int h, input int v, input logic ls, input logic fs);
        exp_t e;
        int   hs0;
        int   vs0;
        hs0  = p_ha[k] + p_hf[k];
        vs0  = p_va[k] + p_vf[k];
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = (h >= hs0 && h < hs0 + p_hs[k]) ? p_pol[k] : ~p_pol[k];
        e.vs = (v >= vs0 && v < vs0 + p_vs[k]) ? p_pol[k] : ~p_pol[k];
        e.vo = (h < p_ha[k]) && (v < p_va[k]);
        e.ls = ls;
        e.fs = fs;
        return e;
    endfunction

    task automatic model_reset();
        m_tap_q = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_h[k]   = htot(k) - 1;
            m_v[k]   = vtot(k) - 1;
            m_le[k]  = 1'b0;
            m_fe[k]  = 1'b0;
            e_out[k] = decode(k, m_h[k], m_v[k], 1'b0, 1'b0);
        end
    endtask

    // Reference model of one clock edge: outputs show the position reached on the previous edge.
    task automatic model_step(input logic tap);
        logic tick;
        logic hw;
        logic vw;
        tick    = tap & ~m_tap_q;
        m_tap_q = tap;
        for (int k = 0; k < 2; k++) begin
            e_out[k] = decode(k, m_h[k], m_v[k], m_le[k], m_fe[k]);
            hw = tick && (m_h[k] == htot(k) - 1);
            vw = hw && (m_v[k] == vtot(k) - 1);
            m_le[k] = hw;
            m_fe[k] = vw;
            if (tick) m_h[k] = hw ? 0 : m_h[k] + 1;
            if (hw)   m_v[k] = vw ? 0 : m_v[k] + 1;
        end
    endtask

    // Drive one clock of stimulus and queue the outputs expected after that edge.
    task automatic cycle(input logic tap, input logic rst);
        reset   = rst;
        div_tap = tap;
        if (!rst) begin
            model_reset();
            if (q0.size() > 0) q0[$] = e_out[0];
            if (q1.size() > 0) q1[$] = e_out[1];
        end
        @(posedge clk);
        if (rst) model_step(tap);
        q0.push_back(e_out[0]);
        q1.push_back(e_out[1]);
        #1;
    endtask

    task automatic report(input int k, input exp_t got, input exp_t want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL sb_dut%0d t=%0t got h=%0d v=%0d hs=%b vs=%b vo=%b ls=%b fs=%b expected h=%0d v=%0d hs=%b vs=%b vo=%b ls=%b fs=%b",
                     k, $time, got.h, got.v, got.hs, got.vs, got.vo, got.ls, got.fs,
                     want.h, want.v, want.hs, want.vs, want.vo, want.ls, want.fs);
        end
    endtask

    // Scoreboard monitor: pops one expectation per instance on each falling edge.
    always @(negedge clk) begin
        exp_t g0;
        exp_t g1;
        g0 = {hcount0, vcount0, hsync0, vsync0, video_on0, line_start0, frame_start0};
        g1 = {hcount1, vcount1, hsync1, vsync1, video_on1, line_start1, frame_start1};
        if (q0.size() > 0) report(0, g0, q0.pop_front());
        if (q1.size() > 0) report(1, g1, q1.pop_front());
    end

    int   prev_h0 = -1, prev_h1 = -1;
    logic prev_hs0 = 1'b1, prev_vo0 = 1'b0, prev_vs1 = 1'b0;
    int   tk0 = 0, tk1 = 0, hs_len = 0, vs_len = 0;
    int   last_ls = -1, last_fs = -1;
    int   n_line_meas = 0, n_frame_meas = 0, n_hs_meas = 0, n_vs_meas = 0;

    // Directed line/frame measurements in pixel ticks, counted from position changes.
    always @(negedge clk) begin
        if (meas_en && int'(hcount0) != prev_h0) begin
            tk0++;
            if (!hsync0 && prev_hs0) chk("hsync_start_col", int'(hcount0), 656);
            if (!hsync0) hs_len++;
            if (hsync0 && !prev_hs0) begin
                chk("hsync_width", hs_len, 96);
                hs_len = 0;
                n_hs_meas++;
            end
            if (!video_on0 && prev_vo0) chk("video_off_col", int'(hcount0), 640);
            if (line_start0) begin
                chk("line_start_col", int'(hcount0), 0);
                if (last_ls >= 0) begin
                    chk("line_period", tk0 - last_ls, 800);
                    n_line_meas++;
                end
                last_ls = tk0;
            end
        end
        if (meas_en && int'(hcount1) != prev_h1) begin
            tk1++;
            if (vsync1 && !prev_vs1) chk("vsync_start_line", int'(vcount1), 8);
            if (vsync1) vs_len++;
            if (!vsync1 && prev_vs1) begin
                chk("vsync_ticks", vs_len, 30);
                vs_len = 0;
                n_vs_meas++;
            end
            if (frame_start1) begin
                chk("frame_origin", int'({hcount1, vcount1}), 0);
                if (last_fs >= 0) begin
                    chk("frame_period", tk1 - last_fs, 195);
                    n_frame_meas++;
                end
                last_fs = tk1;
            end
        end
        prev_h0  = int'(hcount0);
        prev_h1  = int'(hcount1);
        prev_hs0 = hsync0;
        prev_vo0 = video_on0;
        prev_vs1 = vsync1;
    end

    initial begin
        logic found;
        logic held;
        reset   = 1'b0;
        div_tap = 1'b0;
        model_reset();

        for (int i = 0; i < 10; i++) cycle(i[0], 1'b0);

        meas_en = 1'b1;
        for (int i = 0; i < 3400; i++) begin
            cycle(tapc[0], 1'b1);
            tapc++;
        end

        held = tapc[0];
        for (int i = 0; i < 100; i++) cycle(held, 1'b1);

        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cycle(tapc[0], 1'b1);
            tapc++;
            if (hcount0 == 10'd300) found = 1'b1;
        end
        chk("reach_col_300", int'(found), 1);

        meas_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(tapc[0], 1'b0);
            tapc++;
        end
        for (int i = 0; i < 40; i++) begin
            cycle(tapc[0], 1'b1);
            tapc++;
        end

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", q0.size() + q1.size(), 0);
        chk("line_periods_seen", int'(n_line_meas >= 2), 1);
        chk("hsync_pulses_seen", int'(n_hs_meas >= 2), 1);
        chk("frame_periods_seen", int'(n_frame_meas >= 3), 1);
        chk("vsync_pulses_seen", int'(n_vs_meas >= 3), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
